// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Issue/result bundle between the execute stage and the multiply/divide unit.
//   The master (execute stage) drives the operands, the op code and the Start
//   strobe. The slave (mul_div_unit) returns Busy and the HI/LO register pair.
//   Signals:
//     SrcA    [31:0]  multiplicand / dividend / MTHI-MTLO data
//     SrcB    [31:0]  multiplier / divisor
//     MDUCtrl [2:0]   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//     Start           issue strobe, sampled on the rising clock edge
//     Busy            multiply/divide in progress
//     HI      [31:0]  product high word / remainder
//     LO      [31:0]  product low word / quotient
interface mul_div_unit_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  MDUCtrl;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output SrcA, SrcB, MDUCtrl, Start,
    input  Busy, HI, LO
  );

  modport slave (
    input  SrcA, SrcB, MDUCtrl, Start,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division. Each
//   processes one bit per cycle for 32 cycles, followed by one fix-up cycle
//   that applies the sign correction and writes HI/LO. Busy is high for 33
//   cycles in total. MTHI/MTLO write HI or LO directly from IDLE.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mul_div_unit_if.slave (SrcA, SrcB, MDUCtrl, Start in; Busy, HI, LO out)
module mul_div_unit (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Magnitude of a two's-complement word; -2^31 maps to 32'h80000000 read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
    logic [31:0] r;
    if (neg) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] v);
    logic [63:0] r;
    if (neg) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Multiply: acc = {partial product, remaining multiplier bits}; opnd = multiplicand.
  // Divide:   acc = {partial remainder, dividend/quotient bits}; opnd = divisor.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;  // product / quotient is negative
  logic        neg_rem_q, neg_rem_d;  // remainder takes the dividend's sign
  logic        div0_q, div0_d;

  // Per-iteration datapath signals.
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] div_rem_s;
  logic [63:0] div_next_s;

  // Issue decode signals.
  logic        iss_signed_s;
  logic        iss_div_s;
  logic [31:0] iss_a_s;
  logic [31:0] iss_b_s;

  // One shift-add step and one restoring-division step, computed every cycle.
  always_comb begin
    // Add the multiplicand when the current multiplier bit is set, then shift
    // the 65-bit {carry, acc} right by one.
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[63:32]};
    end
    mul_next_s = {mul_sum_s, acc_q[31:1]};

    // Bring the next dividend bit into the 33-bit partial remainder. When the
    // remainder is at least the divisor, the 32-bit difference is exact
    // because the result is below the divisor.
    div_shift_s = {acc_q[63:32], acc_q[31]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    if (div_ge_s) begin
      div_rem_s = div_shift_s[31:0] - opnd_q;
    end else begin
      div_rem_s = div_shift_s[31:0];
    end
    div_next_s = {div_rem_s, acc_q[30:0], div_ge_s};
  end

  // Operand conditioning for a newly issued multiply/divide.
  always_comb begin
    iss_div_s    = bus.MDUCtrl[1];
    iss_signed_s = ~bus.MDUCtrl[0];
    if (iss_signed_s) begin
      iss_a_s = abs32(bus.SrcA);
      iss_b_s = abs32(bus.SrcB);
    end else begin
      iss_a_s = bus.SrcA;
      iss_b_s = bus.SrcB;
    end
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          case (bus.MDUCtrl)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = iss_div_s;
              neg_res_d = iss_signed_s & (bus.SrcA[31] ^ bus.SrcB[31]);
              neg_rem_d = iss_signed_s & bus.SrcA[31];
              div0_d    = iss_div_s & (bus.SrcB == 32'd0);
              if (iss_div_s) begin
                acc_d  = {32'd0, iss_a_s};
                opnd_d = iss_b_s;
              end else begin
                acc_d  = {32'd0, iss_b_s};
                opnd_d = iss_a_s;
              end
              cnt_d   = 5'd0;
              busy_d  = 1'b1;
              state_d = S_RUN;
            end
            OP_MTHI: begin
              hi_d = bus.SrcA;
            end
            OP_MTLO: begin
              lo_d = bus.SrcA;
            end
            default: begin
              // Reserved op codes leave everything untouched.
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_next_s;
        end else begin
          acc_d = mul_next_s;
        end
        // The counter wraps back to 0 after the last iteration.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // Divide-by-zero naturally leaves rem = |dividend|. Applying the
          // dividend's sign restores the original SrcA in HI.
          hi_d = cond_neg32(neg_rem_q, acc_q[63:32]);
          if (div0_q) begin
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = cond_neg32(neg_res_q, acc_q[31:0]);
          end
        end else begin
          {hi_d, lo_d} = cond_neg64(neg_res_q, acc_q);
        end
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed and random checks of mul_div_unit against a plain-arithmetic
//   reference model of HI/LO and a 33-cycle Busy window.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  // Returns {HI, LO} for a multiply/divide op, computed with plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      3'd0: res = sa * sb;
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called just after a rising edge; presents Start for exactly one edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDUCtrl = op;
    bus.SrcA    = a;
    bus.SrcB    = b;
    bus.Start   = 1'b1;
    @(posedge clk);
    #1;
    bus.Start   = 1'b0;
    bus.SrcA    = $urandom;
    bus.SrcB    = $urandom;
    bus.MDUCtrl = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] r;
    int cyc;
    if (op <= 3'd3) begin
      r = ref_op(op, a, b);
      issue(op, a, b);
      check({tag, " hold"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
      cyc = 0;
      while (bus.Busy === 1'b1 && cyc < 100) begin
        cyc++;
        if (cyc == 16) check({tag, " hold_mid"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
      end
      check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      check({tag, " result"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
    end else begin
      if (op == 3'd4) exp_hi = a;
      else if (op == 3'd5) exp_lo = a;
      issue(op, a, b);
      check({tag, " busy"}, {63'd0, bus.Busy}, 64'd0);
      check({tag, " hilo"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
    end
  endtask

  initial begin
    int cyc;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] r;

    bus.Start   = 1'b0;
    bus.SrcA    = 32'd0;
    bus.SrcB    = 32'd0;
    bus.MDUCtrl = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'd0, bus.Busy}, 64'd0);
    check("reset hilo", {bus.HI, bus.LO}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mthi", 3'd4, 32'h1111_2222, 32'd0);
    run_op("mtlo", 3'd5, 32'h3333_4444, 32'd0);
    run_op("rsv6", 3'd6, 32'hDEAD_BEEF, 32'h5);
    run_op("rsv7", 3'd7, 32'hCAFE_F00D, 32'h9);

    run_op("multu_ff_2", 3'd1, 32'hFFFF_FFFF, 32'd2);
    check("multu_ff_2 abs", {bus.HI, bus.LO}, {32'h1, 32'hFFFF_FFFE});
    run_op("mult_m1_2", 3'd0, 32'hFFFF_FFFF, 32'd2);
    check("mult_m1_2 abs", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2 abs", {bus.HI, bus.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    // Issued in the very first cycle after Busy falls.
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    check("divu_100_7 abs", {bus.HI, bus.LO}, {32'd2, 32'd14});
    run_op("divu_5_0", 3'd3, 32'd5, 32'd0);
    check("divu_5_0 abs", {bus.HI, bus.LO}, {32'd5, 32'hFFFF_FFFF});
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1 abs", {bus.HI, bus.LO}, {32'd0, 32'h8000_0000});
    run_op("div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0);
    run_op("mult_min_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE);

    // MTHI while busy must be ignored.
    r = ref_op(3'd1, 32'h0001_2345, 32'h0006_789A);
    issue(3'd1, 32'h0001_2345, 32'h0006_789A);
    cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    issue(3'd4, 32'h0000_ABCD, 32'd0);
    cyc++;
    check("mthi_busy hold", {bus.HI, bus.LO}, {exp_hi, exp_lo});
    while (bus.Busy === 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("mthi_busy cycles", 64'(cyc), 64'd34);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check("mthi_busy result", {bus.HI, bus.LO}, {exp_hi, exp_lo});

    // Random mix of all ops, including reserved codes and zero divisors.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: a = a;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    // Reset in the middle of a multiply abandons it.
    issue(3'd1, 32'h7654_3210, 32'h0123_4567);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", {63'd0, bus.Busy}, 64'd0);
    check("rst_mid hilo", {bus.HI, bus.LO}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_after hilo", {bus.HI, bus.LO}, 64'd0);
    run_op("mtlo_1234", 3'd5, 32'h0000_1234, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
